ni_packetizer: RTL

NI_PACKETIZER -- requirements
Module: ni_packetizer

---
 rtl/ni_packetizer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ni_packetizer.sv
// Network-interface packetizer: turns a send request plus payload words into
// head/body/tail flits for one router input port, with per-VC credit flow control.
module ni_packetizer #(
  parameter logic [3:0]  MY_XPOS   = 4'd0,
  parameter logic [3:0]  MY_YPOS   = 4'd0,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_um,
  input  logic [7:0]  req_dst,
  input  logic [15:0] req_mdst,
  input  logic [1:0]  req_vch,
  input  logic [3:0]  req_len,
  input  logic        pld_valid,
  input  logic [31:0] pld_data,
  output logic        pld_ready,
  input  logic [3:0]  credit_in,
  output logic [35:0] odata,
  output logic        ovalid,
  output logic        busy,
  output logic        cred_err
);

  localparam int unsigned NUM_VC = 4;
  localparam int unsigned CW     = $clog2(BUF_DEPTH + 1);
  localparam int unsigned FW     = 36;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_um;
  logic [7:0]      r_dst;
  logic [15:0]     r_mdst;
  logic [1:0]      r_vch;
  logic [3:0]      r_len;
  logic [3:0]      r_rem;
  logic [CW-1:0]   r_cred [NUM_VC];
  logic [FW-1:0]   r_odata;
  logic            r_ovalid;
  logic            r_cred_err;

  logic            w_cred_ok;
  logic            w_emit;
  logic            w_accept;
  logic [3:0]      w_rem_nxt;
  logic [FW-1:0]   w_flit;
  logic [31:0]     w_head_pld;
  logic [NUM_VC-1:0] w_dec;

  assign w_head_pld = {r_um, 3'b000, r_len, MY_XPOS, MY_YPOS,
                       r_um ? r_mdst : {8'h00, r_dst}};

  // Next-state and flit decision; credit check uses the pre-update count.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    pld_ready   = 1'b0;
    w_emit      = 1'b0;
    w_accept    = 1'b0;
    w_rem_nxt   = r_rem;
    w_flit      = '0;
    w_dec       = '0;
    w_cred_ok   = (r_cred[r_vch] != '0);
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_rem_nxt   = req_len;
          w_state_nxt = S_HEAD;
        end
      end
      S_HEAD: begin
        if (w_cred_ok) begin
          w_emit      = 1'b1;
          w_flit      = {(r_len == 4'd0) ? 2'b11 : 2'b00, r_vch, w_head_pld};
          w_state_nxt = (r_len == 4'd0) ? S_IDLE : S_BODY;
        end
      end
      S_BODY: begin
        if (pld_valid && w_cred_ok) begin
          pld_ready = 1'b1;
          w_emit    = 1'b1;
          w_flit    = {(r_rem == 4'd1) ? 2'b10 : 2'b01, r_vch, pld_data};
          w_rem_nxt = r_rem - 4'd1;
          if (r_rem == 4'd1) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_emit) begin
      w_dec[r_vch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state  <= S_IDLE;
      r_um     <= 1'b0;
      r_dst    <= '0;
      r_mdst   <= '0;
      r_vch    <= '0;
      r_len    <= '0;
      r_rem    <= '0;
      r_odata  <= '0;
      r_ovalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rem    <= w_rem_nxt;
      r_ovalid <= w_emit;
      if (w_emit) begin
        r_odata <= w_flit;
      end
      if (w_accept) begin
        r_um   <= req_um;
        r_dst  <= req_dst;
        r_mdst <= req_mdst;
        r_vch  <= req_vch;
        r_len  <= req_len;
      end
    end
  end

  // Credit counters: a return and an emission on the same VC cancel out.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_cred[v] <= CW'(BUF_DEPTH);
      end
      r_cred_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (credit_in[v] && !w_dec[v]) begin
          if (r_cred[v] == CW'(BUF_DEPTH)) begin
            r_cred_err <= 1'b1;
          end else begin
            r_cred[v] <= r_cred[v] + CW'(1);
          end
        end else if (w_dec[v] && !credit_in[v]) begin
          r_cred[v] <= r_cred[v] - CW'(1);
        end
      end
    end
  end

  assign odata    = r_odata;
  assign ovalid   = r_ovalid;
  assign cred_err = r_cred_err;
  assign busy     = (r_state != S_IDLE) || r_ovalid;

endmodule
